// File: rtl/tm1638_pkg.sv
// Shared constants, FSM state type and byte-stream helper for the TM1638 display writer.
package tm1638_pkg;

   localparam logic [7:0] CMD_WRITE_AUTO = 8'h40;
   localparam logic [7:0] CMD_ADDR0      = 8'hC0;
   localparam logic [7:0] CMD_DISP_BASE  = 8'h80;
   localparam int         NUM_DIGITS     = 8;
   localparam int         NUM_BYTES      = 19;
   localparam logic [4:0] LAST_BYTE      = 5'(NUM_BYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEAD,
      S_SHIFT,
      S_TRAIL,
      S_GAP,
      S_DONE
   } state_t;

   // Byte idx of the 19-byte refresh stream; data bytes alternate digit segments and LED bits.
   function automatic logic [7:0] stream_byte(
      input logic [4:0]                  idx,
      input logic [8*NUM_DIGITS-1:0]     seg,
      input logic [NUM_DIGITS-1:0]       led,
      input logic                        disp_on,
      input logic [2:0]                  bright
   );
      logic [3:0] addr;
      addr = 4'(idx - 5'd2);
      if (idx == 5'd0)      return CMD_WRITE_AUTO;
      if (idx == 5'd1)      return CMD_ADDR0;
      if (idx == LAST_BYTE) return CMD_DISP_BASE | {4'b0000, disp_on, bright};
      if (addr[0])          return {7'b0, led[addr[3:1]]};
      return seg[8*addr[3:1] +: 8];
   endfunction

endpackage

// File: rtl/tm1638_bit_tick.sv
// Half-bit timer: down-counter reloaded on clear or terminal count; phase flips each half bit.
module tm1638_bit_tick #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick,
   output logic phase,
   output logic phase_next
);

   localparam int            CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

   logic [CW-1:0] count;

   assign tick       = (count == '0);
   assign phase_next = clear ? 1'b0 : (tick ? ~phase : phase);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= RELOAD;
         phase <= 1'b0;
      end else begin
         phase <= phase_next;
         if (clear || tick) count <= RELOAD;
         else               count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/tm1638_display_writer.sv
// Write-only TM1638 refresh engine: snapshots digits/LEDs/brightness and sends 19 bytes in 3 frames.
//  state   | meaning
//  IDLE    | waiting for start, pins idle high
//  LEAD    | STB low, CLK high, CLK_DIV cycles before the first bit
//  SHIFT   | serialising bytes LSB first, one bit per 2*CLK_DIV cycles
//  TRAIL   | STB low, CLK/DIO high, CLK_DIV cycles after the last bit
//  GAP     | STB high for 2*CLK_DIV cycles between frames
//  DONE    | one-cycle completion pulse
module tm1638_display_writer
   import tm1638_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [8*NUM_DIGITS-1:0]   seg_data,
   input  logic [NUM_DIGITS-1:0]     led,
   input  logic                      disp_on,
   input  logic [2:0]                bright,
   output logic                      busy,
   output logic                      done,
   output logic                      tm_stb,
   output logic                      tm_clk,
   output logic                      tm_dio
);

   state_t                    state, state_n;
   logic [2:0]                bit_cnt, bit_n;
   logic [4:0]                byte_idx, byte_n;
   logic [8*NUM_DIGITS-1:0]   seg_q;
   logic [NUM_DIGITS-1:0]     led_q;
   logic                      on_q;
   logic [2:0]                br_q;
   logic                      tick, phase, phase_n, clear, frame_end;
   logic [7:0]                next_byte;
   logic                      stb_d, clk_d, dio_d, busy_d, done_d;

   tm1638_bit_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .tick       (tick),
      .phase      (phase),
      .phase_next (phase_n)
   );

   assign frame_end = (byte_idx == 5'd0) || (byte_idx == LAST_BYTE - 5'd1) || (byte_idx == LAST_BYTE);

   always_comb begin
      state_n = state;
      bit_n   = bit_cnt;
      byte_n  = byte_idx;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_n = S_LEAD;
               bit_n   = 3'd0;
               byte_n  = 5'd0;
            end
         end
         S_LEAD:  if (tick) state_n = S_SHIFT;
         S_SHIFT: begin
            if (tick && phase) begin
               bit_n = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  // Frame-final byte keeps its index; GAP advances it so the index never exceeds 18.
                  if (frame_end) state_n = S_TRAIL;
                  else           byte_n  = byte_idx + 5'd1;
               end
            end
         end
         S_TRAIL: if (tick) state_n = S_GAP;
         S_GAP: begin
            if (tick && phase) begin
               if (byte_idx == LAST_BYTE) begin
                  state_n = S_DONE;
                  byte_n  = 5'd0;
               end else begin
                  state_n = S_LEAD;
                  byte_n  = byte_idx + 5'd1;
               end
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Pin values are derived from next-state so they can be registered without a cycle of lag.
   always_comb begin
      clear     = (state_n != state);
      next_byte = stream_byte(byte_n, seg_q, led_q, on_q, br_q);
      stb_d     = 1'b1;
      clk_d     = 1'b1;
      dio_d     = 1'b1;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      case (state_n)
         S_LEAD, S_TRAIL: begin
            stb_d  = 1'b0;
            busy_d = 1'b1;
         end
         S_SHIFT: begin
            stb_d  = 1'b0;
            clk_d  = phase_n;
            dio_d  = next_byte[bit_n];
            busy_d = 1'b1;
         end
         S_GAP:   busy_d = 1'b1;
         S_DONE:  done_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         bit_cnt  <= 3'd0;
         byte_idx <= 5'd0;
         seg_q    <= '0;
         led_q    <= '0;
         on_q     <= 1'b0;
         br_q     <= 3'd0;
         busy     <= 1'b0;
         done     <= 1'b0;
         tm_stb   <= 1'b1;
         tm_clk   <= 1'b1;
         tm_dio   <= 1'b1;
      end else begin
         state    <= state_n;
         bit_cnt  <= bit_n;
         byte_idx <= byte_n;
         if (state == S_IDLE && start) begin
            seg_q <= seg_data;
            led_q <= led;
            on_q  <= disp_on;
            br_q  <= bright;
         end
         busy     <= busy_d;
         done     <= done_d;
         tm_stb   <= stb_d;
         tm_clk   <= clk_d;
         tm_dio   <= dio_d;
      end
   end

endmodule
